// File: rtl/src_ctrl_fsm_pkg.sv
// Shared definitions for the source-control FSM: state index layout and led bit positions.
// The state index doubles as the led bit position, so led is a plain one-hot decode of the state.
package ctrl_pkg;

  localparam int MAX_SRC = 8;
  localparam int ST_W    = $clog2(2 * MAX_SRC + 2);

  typedef logic [ST_W-1:0] state_t;

  function automatic int led_idle_bit();
    return 0;
  endfunction

  function automatic int led_comm_bit(input int src);
    return 1 + 2 * src;
  endfunction

  function automatic int led_wait_bit(input int src);
    return 2 + 2 * src;
  endfunction

  function automatic int led_buf_empty_bit(input int num_src);
    return 2 * num_src + 1;
  endfunction

  function automatic state_t idle_idx();
    return state_t'(led_idle_bit());
  endfunction

  function automatic state_t comm_idx(input int src);
    return state_t'(led_comm_bit(src));
  endfunction

  function automatic state_t wait_idx(input int src);
    return state_t'(led_wait_bit(src));
  endfunction

  function automatic state_t buf_empty_idx(input int num_src);
    return state_t'(led_buf_empty_bit(num_src));
  endfunction

endpackage

// File: rtl/src_ctrl_fsm_btn_edge.sv
// Button conditioner: STAGES-deep synchroniser followed by a rising-edge detector.
// A level first sampled at edge k produces a pulse that the consumer acts on at edge k+STAGES.
module btn_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Clearing prev_q in reset makes a button held through reset give exactly one pulse afterwards.
  assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/src_ctrl_fsm.sv
// Producer/consumer control FSM: arbitrates NUM_SRC producers into one shared buffer,
// drains on stop and latches the slow-clock frequency code on an update press.
module src_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int PROG_W      = 3,
  parameter int NUM_FREQ    = 5,
  parameter int PROG_RST    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_SRC-1:0]                             start,
  input  logic                                           stop,
  input  logic                                           update,
  input  logic [PROG_W-1:0]                              prog,
  input  logic                                           buf_full,
  input  logic                                           buf_empty,
  input  logic                                           data_valid,
  output logic [NUM_SRC-1:0]                             prod_en,
  output logic                                           cons_en,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] src_sel,
  output logic [PROG_W-1:0]                              prog_q,
  output logic                                           prog_load,
  output logic [2*NUM_SRC+1:0]                           led
);

  localparam int     SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int     NUM_BTN = NUM_SRC + 2;
  localparam int     LED_W   = 2 * NUM_SRC + 2;
  localparam state_t ST_IDLE = idle_idx();
  localparam state_t ST_BE   = buf_empty_idx(NUM_SRC);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [NUM_SRC-1:0] start_pulse;
  logic               stop_pulse;
  logic               update_pulse;

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   src_sel_nxt;
  logic [SEL_W-1:0]   first_src;
  logic [PROG_W-1:0]  prog_sat;

  assign btn_raw = {update, stop, start};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_edge #(
      .STAGES(SYNC_STAGES)
    ) u_btn_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_raw[g]),
      .pulse(btn_pulse[g])
    );
  end

  assign start_pulse  = btn_pulse[NUM_SRC-1:0];
  assign stop_pulse   = btn_pulse[NUM_SRC];
  assign update_pulse = btn_pulse[NUM_SRC+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      src_sel <= '0;
    end else begin
      state   <= state_nxt;
      src_sel <= src_sel_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = ST_IDLE;
    src_sel_nxt = src_sel;
    first_src   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (start_pulse[i]) first_src = SEL_W'(i);
    end

    if (state == ST_IDLE) begin
      if (|start_pulse) begin
        state_nxt   = comm_idx(int'(first_src));
        src_sel_nxt = first_src;
      end
    end else if (state == ST_BE) begin
      state_nxt = (buf_empty && !data_valid) ? ST_IDLE : ST_BE;
    end else begin
      // Unencoded indices match nothing below and fall back to IDLE.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (state == comm_idx(i)) begin
          if (stop_pulse)    state_nxt = ST_BE;
          else if (buf_full) state_nxt = wait_idx(i);
          else               state_nxt = state;
        end else if (state == wait_idx(i)) begin
          if (stop_pulse)     state_nxt = ST_BE;
          else if (!buf_full) state_nxt = comm_idx(i);
          else                state_nxt = state;
        end
      end
    end
  end

  always_comb begin
    led     = '0;
    prod_en = '0;
    for (int j = 0; j < LED_W; j++) begin
      led[j] = (state == state_t'(j));
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      prod_en[i] = (state == comm_idx(i));
    end
    cons_en = (state != ST_IDLE) && (state <= ST_BE);
  end

  // Frequency select is independent of the FSM state.
  assign prog_sat = (int'(prog) >= NUM_FREQ) ? PROG_W'(NUM_FREQ - 1) : prog;

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_q    <= PROG_W'(PROG_RST);
      prog_load <= 1'b0;
    end else begin
      prog_load <= update_pulse;
      if (update_pulse) prog_q <= prog_sat;
    end
  end

endmodule
